// File: rtl/fpnew_pkg.sv
// Shared FPU types: exception status flags carried alongside every result.
package fpnew_pkg;

  // IEEE 754 exception flags, MSB first: {NV, DZ, OF, UF, NX}.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of_;
    logic uf;
    logic nx;
  } status_t;

endpackage

// File: rtl/fpnew_fifo_ctrl.sv
// FIFO control for the integer result stage: read/write pointers, entry count,
// handshake qualification and flush. Depth must be a power of two, >= 2.
module fpnew_fifo_ctrl #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_req_i,
  input  logic            pop_req_i,
  output logic            push_o,
  output logic            pop_o,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [CntW-1:0] count_o,
  output logic            in_ready_o,
  output logic            out_valid_o
);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Ready depends only on registered state, so a full FIFO never accepts
  // a push even when the head is retiring in the same cycle.
  assign in_ready_o  = (count_q != CntW'(Depth));
  assign out_valid_o = (count_q != '0);

  // A flush suppresses both handshakes so nothing is written or retired.
  assign push_o = push_req_i & in_ready_o & ~flush_i;
  assign pop_o  = pop_req_i & out_valid_o & ~flush_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_o) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_o)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_o, pop_o})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/fpnew_int_result_stage.sv
// Buffers float-to-int cast results ahead of integer writeback, sign-extends
// them to register width and accumulates sticky fflags at retirement.
module fpnew_int_result_stage
  import fpnew_pkg::*;
#(
  parameter int unsigned InWidth  = 64,
  parameter int unsigned OutWidth = 64,
  parameter int unsigned Depth    = 2,
  parameter type         TagType  = logic,
  localparam int unsigned CntW    = $clog2(Depth + 1),
  localparam int unsigned PtrW    = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [InWidth-1:0]  result_i,
  input  status_t             status_i,
  input  logic                extension_bit_i,
  input  TagType              tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [OutWidth-1:0] result_o,
  output status_t             status_o,
  output TagType              tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output status_t             fflags_o,
  input  logic                fflags_clr_i,
  output logic [CntW-1:0]     occupancy_o,
  output logic                busy_o
);

  logic            push, pop;
  logic [PtrW-1:0] wr_ptr, rd_ptr;

  fpnew_fifo_ctrl #(.Depth(Depth)) u_ctrl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_req_i  (in_valid_i),
    .pop_req_i   (out_ready_i),
    .push_o      (push),
    .pop_o       (pop),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (occupancy_o),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o)
  );

  logic [InWidth-1:0] result_mem [Depth];
  status_t            status_mem [Depth];
  logic               ext_mem    [Depth];
  TagType             tag_mem    [Depth];

  // NOTE: storage is deliberately not reset; validity is tracked solely by
  // the control count, so resetting the array would only cost area.
  always_ff @(posedge clk_i) begin
    if (push) begin
      result_mem[wr_ptr] <= result_i;
      status_mem[wr_ptr] <= status_i;
      ext_mem[wr_ptr]    <= extension_bit_i;
      tag_mem[wr_ptr]    <= tag_i;
    end
  end

  if (OutWidth > InWidth) begin : g_ext
    assign result_o = {{(OutWidth - InWidth){ext_mem[rd_ptr]}}, result_mem[rd_ptr]};
  end else begin : g_no_ext
    assign result_o = result_mem[rd_ptr];
  end

  assign status_o = status_mem[rd_ptr];
  assign tag_o    = tag_mem[rd_ptr];
  assign busy_o   = out_valid_o | in_valid_i;

  status_t fflags_q, fflags_d;

  // Clear applies first, so clear plus pop leaves exactly the popped flags.
  // NOTE: every always_comb output gets a default first to avoid latches.
  always_comb begin
    fflags_d = fflags_clr_i ? status_t'('0) : fflags_q;
    if (pop) fflags_d = fflags_d | status_mem[rd_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) fflags_q <= '0;
    else       fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpnew_int_result_stage.sv
// Scoreboard bench for fpnew_int_result_stage (32-bit results into 64-bit regs).
module tb_fpnew_int_result_stage;
  import fpnew_pkg::*;

  localparam int unsigned IW = 32;
  localparam int unsigned OW = 64;
  localparam int unsigned DEPTH = 2;
  typedef logic [3:0] tag_t;

  typedef struct {
    logic [OW-1:0] res;
    logic [4:0]    st;
    tag_t          tag;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [IW-1:0] result_i = '0;
  status_t       status_i = '0;
  logic          extension_bit_i = 1'b0;
  tag_t          tag_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          flush_i = 1'b0;
  logic [OW-1:0] result_o;
  status_t       status_o;
  tag_t          tag_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  status_t       fflags_o;
  logic          fflags_clr_i = 1'b0;
  logic [1:0]    occupancy_o;
  logic          busy_o;

  fpnew_int_result_stage #(
    .InWidth(IW), .OutWidth(OW), .Depth(DEPTH), .TagType(tag_t)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .result_i(result_i), .status_i(status_i),
    .extension_bit_i(extension_bit_i), .tag_i(tag_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .flush_i(flush_i), .result_o(result_o),
    .status_o(status_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .occupancy_o(occupancy_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  logic [4:0] ff_model = '0;
  int   n_popped = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare outputs against the model just before the edge, then advance the model.
  task automatic step();
    logic exp_valid, exp_ready, do_pop, do_push;
    exp_t e;
    @(negedge clk_i);
    exp_valid = (sb_q.size() != 0);
    exp_ready = (sb_q.size() != DEPTH);
    if (!rst_i) begin
      check("out_valid", 64'(out_valid_o), 64'(exp_valid));
      check("in_ready",  64'(in_ready_o),  64'(exp_ready));
      check("occupancy", 64'(occupancy_o), 64'(sb_q.size()));
      check("busy",      64'(busy_o),      64'(exp_valid | in_valid_i));
      check("fflags",    64'(fflags_o),    64'(ff_model));
      if (exp_valid) begin
        check("result", result_o, sb_q[0].res);
        check("status", 64'(status_o), 64'(sb_q[0].st));
        check("tag",    64'(tag_o),    64'(sb_q[0].tag));
      end
    end
    if (rst_i) begin
      sb_q.delete();
      ff_model = '0;
    end else begin
      do_pop  = exp_valid && out_ready_i && !flush_i;
      do_push = in_valid_i && exp_ready && !flush_i;
      if (fflags_clr_i) ff_model = '0;
      if (do_pop) begin
        ff_model = ff_model | sb_q[0].st;
        void'(sb_q.pop_front());
        n_popped++;
      end
      if (flush_i) sb_q.delete();
      if (do_push) begin
        e.res = {{(OW-IW){extension_bit_i}}, result_i};
        e.st  = status_i;
        e.tag = tag_i;
        sb_q.push_back(e);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] r, input logic ext,
                       input logic [4:0] st, input tag_t tg);
    in_valid_i = v;
    result_i = r;
    extension_bit_i = ext;
    status_i = status_t'(st);
    tag_i = tg;
  endtask

  initial begin
    // Reset
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_in_ready",  64'(in_ready_o),  64'd1);
    check("rst_fflags",    64'(fflags_o),    64'd0);
    check("rst_occupancy", 64'(occupancy_o), 64'd0);
    check("rst_busy",      64'(busy_o),      64'd0);

    // Single op with sign extension, NX
    out_ready_i = 1'b1;
    drive(1'b1, 32'h8000_0000, 1'b1, 5'h01, 4'd0);
    step();
    drive(1'b0, '0, 1'b0, 5'h00, 4'd0);
    check("single_valid",  64'(out_valid_o), 64'd1);
    check("single_result", result_o, 64'hFFFF_FFFF_8000_0000);
    step();
    check("single_fflags", 64'(fflags_o), 64'h01);

    // Fill, overflow attempt, ordered drain
    out_ready_i = 1'b0;
    drive(1'b1, 32'h0000_0011, 1'b0, 5'h00, 4'd1);
    step();
    drive(1'b1, 32'h0000_0022, 1'b0, 5'h00, 4'd2);
    step();
    check("full_in_ready",  64'(in_ready_o),  64'd0);
    check("full_occupancy", 64'(occupancy_o), 64'd2);
    drive(1'b1, 32'h0000_0033, 1'b0, 5'h00, 4'd3);
    step();
    drive(1'b0, '0, 1'b0, 5'h00, 4'd0);
    out_ready_i = 1'b1;
    check("drain_tag1", 64'(tag_o), 64'd1);
    step();
    check("drain_tag2", 64'(tag_o), 64'd2);
    step();
    check("drain_empty", 64'(out_valid_o), 64'd0);

    // Streaming: one in, one out per cycle
    n_popped = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'($urandom), 1'($urandom_range(0, 1)), 5'h00, 4'(i));
      step();
      if (i > 0) check("stream_occupancy", 64'(occupancy_o), 64'd1);
    end
    drive(1'b0, '0, 1'b0, 5'h00, 4'd0);
    step();
    check("stream_pops", 64'(n_popped), 64'd10);

    // Flag accumulation: NV then OF, then clear together with an NX pop
    fflags_clr_i = 1'b1;
    out_ready_i = 1'b0;
    drive(1'b1, 32'h1, 1'b0, 5'h10, 4'd4);
    step();
    fflags_clr_i = 1'b0;
    drive(1'b1, 32'h2, 1'b0, 5'h04, 4'd5);
    step();
    drive(1'b0, '0, 1'b0, 5'h00, 4'd0);
    out_ready_i = 1'b1;
    step();
    step();
    check("flags_nv_of", 64'(fflags_o), 64'h14);
    out_ready_i = 1'b0;
    drive(1'b1, 32'h3, 1'b0, 5'h01, 4'd6);
    step();
    drive(1'b0, '0, 1'b0, 5'h00, 4'd0);
    out_ready_i = 1'b1;
    fflags_clr_i = 1'b1;
    step();
    fflags_clr_i = 1'b0;
    check("flags_clr_pop", 64'(fflags_o), 64'h01);

    // Flush with two NV entries; push and pop in the flush cycle are ignored
    out_ready_i = 1'b0;
    drive(1'b1, 32'h4, 1'b0, 5'h10, 4'd7);
    step();
    drive(1'b1, 32'h5, 1'b0, 5'h10, 4'd8);
    step();
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, 32'h6, 1'b0, 5'h10, 4'd9);
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, 1'b0, 5'h00, 4'd0);
    check("flush_occupancy", 64'(occupancy_o), 64'd0);
    check("flush_valid",     64'(out_valid_o), 64'd0);
    check("flush_fflags",    64'(fflags_o),    64'h01);
    step();

    // Reset with one entry held
    out_ready_i = 1'b0;
    drive(1'b1, 32'h7, 1'b0, 5'h08, 4'd10);
    step();
    drive(1'b0, '0, 1'b0, 5'h00, 4'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst2_valid",    64'(out_valid_o), 64'd0);
    check("rst2_fflags",   64'(fflags_o),    64'd0);
    check("rst2_in_ready", 64'(in_ready_o),  64'd1);
    step();
    check("end_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
